hpio_rx: RTL and testbench

- Behavioural single-clock model of the HPIO receive port used in the loopback link.
- Takes a differential serial data pair and a differential forwarded-clock pair, one bit per clk on each pin.
- Deserializes 1:8 MSB-first, aligns word boundaries to a fixed pattern on the clock lane, and buffers each lane in a small FIFO.
- Presents PLL/delay/VTC ready status and a reset-sequence-done flag, as the hardware IP does.

---
 rtl/hpio_rx_pkg.sv | 18 +
 rtl/hpio_rx_lane_fifo.sv | 55 +++++
 rtl/hpio_rx.sv | 223 ++++++++++++++++++++++
 tb/tb_hpio_rx.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/hpio_rx_pkg.sv
// hpio_rx_pkg
//   Shared definitions for the HPIO receive port model.
//   - WORD_W            : deserialized word width (bits per lane word).
//   - ALIGN_PATTERN_DEF : default word expected on the forwarded-clock P lane
//                         at a word boundary.
//   - state_e           : receive state machine encoding (IDLE, ALIGN, RUN).
package hpio_rx_pkg;

  localparam int WORD_W = 8;
  localparam logic [WORD_W-1:0] ALIGN_PATTERN_DEF = 8'hAA;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ALIGN = 2'd1,
    ST_RUN   = 2'd2
  } state_e;

endpackage

// File: rtl/hpio_rx_lane_fifo.sv
// hpio_rx_lane_fifo
//   Synchronous single-clock FIFO holding deserialized words for one lane.
//   Ports:
//     clk, rst_n  : clock, asynchronous active-low reset (empties the FIFO)
//     push, din   : write request and word
//     pop         : read request; dout shows the head word while !empty
//     full, empty : occupancy flags (combinational from the pointers)
//   Handshake: a push is taken only when the FIFO is not full (a push into a
//   full FIFO drops the word); a pop is taken only when it is not empty. Both
//   may be taken in the same cycle.
module hpio_rx_lane_fifo
  import hpio_rx_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic              pop,
  input  logic [WORD_W-1:0] din,
  output logic              full,
  output logic              empty,
  output logic [WORD_W-1:0] dout
);

  localparam int AW = $clog2(DEPTH);

  logic [WORD_W-1:0] mem [DEPTH];
  // One extra pointer bit separates the full and empty cases.
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  logic        wr_en;
  logic        rd_en;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign wr_en = push && !full;
  assign rd_en = pop && !empty;
  assign dout  = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/hpio_rx.sv
// hpio_rx
//   Behavioural single-clock model of the HPIO receive port. Each of four
//   lanes (data P/N, forwarded clock P/N) supplies one bit per clk; bits are
//   deserialized 1:8 MSB-first, word boundaries are found from a fixed
//   pattern on the clock P lane, and each lane's words are buffered in a
//   small FIFO. Words leave all four FIFOs in lockstep.
//   Optional feature: define HPIO_RX_DIFF_CHECK_EN to add the sticky diff_err
//   output flagging a non-complementary P/N pair while ALIGN or RUN.
//   Ports:
//     clk, rst                         : clock, asynchronous active-low reset
//     bg1_pin0_nc                      : unused input
//     bg1_pin8_data_p_21/_n_22         : serial data P/N
//     clk_p_26 / clk_n_27              : forwarded clock lane P/N
//     en_vtc_bsc2/3/4                  : VTC enables
//     data_to_fabric_*                 : deserialized words (one per lane)
//     fifo_empty_*                     : per-lane FIFO empty
//     fifo_rd_data_valid               : data_to_fabric_* updated this cycle
//     pll0_locked, dly_rdy_bsc*, vtc_rdy_bsc*, rst_seq_done : status
//     dbg_state                        : receive state machine state
//     diff_err (optional)              : sticky P/N complement error
module hpio_rx
  import hpio_rx_pkg::*;
#(
  parameter int                LOCK_CYCLES   = 64,
  parameter int                DLY_CYCLES    = 16,
  parameter int                FIFO_DEPTH    = 8,
  parameter logic [WORD_W-1:0] ALIGN_PATTERN = ALIGN_PATTERN_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              bg1_pin0_nc,
  input  logic              bg1_pin8_data_p_21,
  input  logic              bg1_pin9_data_n_22,
  input  logic              clk_p_26,
  input  logic              clk_n_27,
  input  logic              en_vtc_bsc2,
  input  logic              en_vtc_bsc3,
  input  logic              en_vtc_bsc4,
  output logic [WORD_W-1:0] data_to_fabric_bg1_pin8_data_p_21,
  output logic [WORD_W-1:0] data_to_fabric_bg1_pin9_data_n_22,
  output logic [WORD_W-1:0] data_to_fabric_clk_p_26,
  output logic [WORD_W-1:0] data_to_fabric_clk_n_27,
  output logic              fifo_empty_21,
  output logic              fifo_empty_22,
  output logic              fifo_empty_26,
  output logic              fifo_empty_27,
  output logic              fifo_rd_data_valid,
  output logic              pll0_locked,
  output logic              dly_rdy_bsc2,
  output logic              dly_rdy_bsc3,
  output logic              dly_rdy_bsc4,
  output logic              vtc_rdy_bsc2,
  output logic              vtc_rdy_bsc3,
  output logic              vtc_rdy_bsc4,
  output logic              rst_seq_done,
  output state_e            dbg_state
`ifdef HPIO_RX_DIFF_CHECK_EN
  ,
  output logic              diff_err
`endif
);

  localparam logic [15:0] LOCK_LAST = 16'(LOCK_CYCLES - 1);
  localparam logic [15:0] DLY_LAST  = 16'(DLY_CYCLES - 1);

  // Lane index: 0 = data P, 1 = data N, 2 = clock P, 3 = clock N.
  localparam int CLK_LANE = 2;

  logic              unused_nc;
  logic [3:0]        unused_full;
  logic [15:0]       lock_cnt;
  logic [15:0]       dly_cnt;
  logic              dly_rdy;
  logic [2:0]        vtc_q;
  state_e            state_q, state_d;
  logic [2:0]        align_cnt;
  logic [2:0]        bit_cnt;
  logic [3:0]        pin_bits;
  logic [3:0][WORD_W-1:0] sr_q;
  logic [3:0][WORD_W-1:0] sr_nxt;
  logic [3:0][WORD_W-1:0] lane_dout;
  logic [3:0][WORD_W-1:0] data_q;
  logic [3:0]        lane_empty;
  logic [3:0]        lane_full;
  logic              push;
  logic              pop;
  logic              valid_q;

  assign unused_nc   = bg1_pin0_nc;
  assign unused_full = lane_full;
  assign pin_bits    = {clk_n_27, clk_p_26, bg1_pin9_data_n_22, bg1_pin8_data_p_21};

  // Startup sequence: PLL lock, then delay-line ready, then reset-sequence done.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lock_cnt     <= '0;
      dly_cnt      <= '0;
      pll0_locked  <= 1'b0;
      dly_rdy      <= 1'b0;
      rst_seq_done <= 1'b0;
      vtc_q        <= '0;
    end else begin
      if (!pll0_locked) begin
        lock_cnt <= lock_cnt + 1'b1;
        if (lock_cnt == LOCK_LAST) pll0_locked <= 1'b1;
      end
      if (pll0_locked && !dly_rdy) begin
        dly_cnt <= dly_cnt + 1'b1;
        if (dly_cnt == DLY_LAST) dly_rdy <= 1'b1;
      end
      rst_seq_done <= dly_rdy;
      // rst_seq_done is the registered copy of dly_rdy; gating it with the
      // enables here gives vtc_rdy its one-cycle response to en_vtc.
      vtc_q <= {3{rst_seq_done}} & {en_vtc_bsc4, en_vtc_bsc3, en_vtc_bsc2};
    end
  end

  assign dly_rdy_bsc2 = dly_rdy;
  assign dly_rdy_bsc3 = dly_rdy;
  assign dly_rdy_bsc4 = dly_rdy;
  assign vtc_rdy_bsc2 = vtc_q[0];
  assign vtc_rdy_bsc3 = vtc_q[1];
  assign vtc_rdy_bsc4 = vtc_q[2];

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      sr_nxt[i] = {sr_q[i][WORD_W-2:0], pin_bits[i]};
    end
  end

  // Receive state machine.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= ST_IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    push    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (rst_seq_done) state_d = ST_ALIGN;
      end
      ST_ALIGN: begin
        // align_cnt saturates at 7: this clk shifts in at least the 8th bit.
        if (align_cnt == 3'd7 && sr_nxt[CLK_LANE] == ALIGN_PATTERN) begin
          push    = 1'b1;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (bit_cnt == 3'd7) push = 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign dbg_state = state_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sr_q      <= '0;
      align_cnt <= '0;
      bit_cnt   <= '0;
    end else begin
      if (state_q != ST_IDLE) sr_q <= sr_nxt;
      if (state_q == ST_ALIGN && align_cnt != 3'd7) align_cnt <= align_cnt + 1'b1;
      // Held at 0 until RUN, so it starts from 0 right after the boundary.
      if (state_q == ST_RUN) bit_cnt <= bit_cnt + 1'b1;
      else                   bit_cnt <= '0;
    end
  end

  for (genvar g = 0; g < 4; g++) begin : g_lane
    hpio_rx_lane_fifo #(
      .DEPTH (FIFO_DEPTH)
    ) u_fifo (
      .clk   (clk),
      .rst_n (rst),
      .push  (push),
      .pop   (pop),
      .din   (sr_nxt[g]),
      .full  (lane_full[g]),
      .empty (lane_empty[g]),
      .dout  (lane_dout[g])
    );
  end

  // Lanes are read in lockstep so words from one boundary stay together.
  assign pop = ~|lane_empty;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      valid_q <= pop;
      if (pop) data_q <= lane_dout;
    end
  end

  assign data_to_fabric_bg1_pin8_data_p_21 = data_q[0];
  assign data_to_fabric_bg1_pin9_data_n_22 = data_q[1];
  assign data_to_fabric_clk_p_26           = data_q[2];
  assign data_to_fabric_clk_n_27           = data_q[3];
  assign fifo_empty_21      = lane_empty[0];
  assign fifo_empty_22      = lane_empty[1];
  assign fifo_empty_26      = lane_empty[2];
  assign fifo_empty_27      = lane_empty[3];
  assign fifo_rd_data_valid = valid_q;

`ifdef HPIO_RX_DIFF_CHECK_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      diff_err <= 1'b0;
    end else if (state_q != ST_IDLE &&
                 ((pin_bits[0] == pin_bits[1]) || (pin_bits[2] == pin_bits[3]))) begin
      diff_err <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_hpio_rx.sv
// tb_hpio_rx
//   Self-checking bench for hpio_rx. Drives the four serial lanes one bit per
//   clk, keeps a reference model of the expected word stream, status timing
//   and FIFO occupancy, and reports a one-line summary.
//   Build with HPIO_RX_DIFF_CHECK_EN defined to also cover diff_err.
module tb_hpio_rx;
  import hpio_rx_pkg::*;

  localparam int LOCK        = 64;
  localparam int DLY         = 16;
  // pll at LOCK, dly at +DLY, done +1, state leaves IDLE +1, first shift +1.
  localparam int FIRST_SHIFT = LOCK + DLY + 3;

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUT ----------------
  logic        pin0_nc, data_p, data_n, ck_p, ck_n;
  logic        en2, en3, en4;
  logic [7:0]  d21, d22, d26, d27;
  logic        e21, e22, e26, e27;
  logic        rd_valid, pll0_locked, dly2, dly3, dly4, vtc2, vtc3, vtc4, rsd;
  state_e      dbg_state;
`ifdef HPIO_RX_DIFF_CHECK_EN
  logic        diff_err;
`endif

  hpio_rx dut (
    .clk                               (clk),
    .rst                               (rst),
    .bg1_pin0_nc                       (pin0_nc),
    .bg1_pin8_data_p_21                (data_p),
    .bg1_pin9_data_n_22                (data_n),
    .clk_p_26                          (ck_p),
    .clk_n_27                          (ck_n),
    .en_vtc_bsc2                       (en2),
    .en_vtc_bsc3                       (en3),
    .en_vtc_bsc4                       (en4),
    .data_to_fabric_bg1_pin8_data_p_21 (d21),
    .data_to_fabric_bg1_pin9_data_n_22 (d22),
    .data_to_fabric_clk_p_26           (d26),
    .data_to_fabric_clk_n_27           (d27),
    .fifo_empty_21                     (e21),
    .fifo_empty_22                     (e22),
    .fifo_empty_26                     (e26),
    .fifo_empty_27                     (e27),
    .fifo_rd_data_valid                (rd_valid),
    .pll0_locked                       (pll0_locked),
    .dly_rdy_bsc2                      (dly2),
    .dly_rdy_bsc3                      (dly3),
    .dly_rdy_bsc4                      (dly4),
    .vtc_rdy_bsc2                      (vtc2),
    .vtc_rdy_bsc3                      (vtc3),
    .vtc_rdy_bsc4                      (vtc4),
    .rst_seq_done                      (rsd),
    .dbg_state                         (dbg_state)
`ifdef HPIO_RX_DIFF_CHECK_EN
    ,
    .diff_err                          (diff_err)
`endif
  );

  // ---------------- scoreboard state ----------------
  int          n_checks;
  int          n_errors;
  int          e;              // clk edges since reset release
  logic [7:0]  hist [4];       // last 8 bits seen on each lane since ALIGN
  bit          aligned;
  int          kb;             // shift index of the word boundary
  logic [31:0] exp_q[$];       // expected {p21, n22, p26, n27} words
  int          exp_edge_q[$];  // edge at which each word should be valid
  logic [31:0] last_words;
  int          n_valid;
  logic [7:0]  cur_byte;
  bit          vtc_test;
  int          vtc_off_at;
  int          diff_at;
  bit          diff_exp;
  bit          diff_done;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s @edge %0d: got %0h expected %0h", tag, e, got, exp);
    end
  endtask

  task automatic reset_model();
    e          = 0;
    for (int l = 0; l < 4; l++) hist[l] = 8'h00;
    aligned    = 1'b0;
    kb         = 0;
    exp_q.delete();
    exp_edge_q.delete();
    last_words = '0;
    n_valid    = 0;
    cur_byte   = 8'h00;
    vtc_test   = 1'b0;
    vtc_off_at = -1;
    diff_at    = -1;
    diff_exp   = 1'b0;
    diff_done  = 1'b0;
  endtask

  task automatic check_reset_values();
    check("rst_status", {pll0_locked, dly2, dly3, dly4, vtc2, vtc3, vtc4, rsd}, 8'h00);
    check("rst_empty", {e21, e22, e26, e27}, 4'hF);
    check("rst_data", {d21, d22, d26, d27}, 32'h0);
    check("rst_valid", rd_valid, 1'b0);
    check("rst_state", dbg_state, ST_IDLE);
`ifdef HPIO_RX_DIFF_CHECK_EN
    check("rst_diff_err", diff_err, 1'b0);
`endif
  endtask

  task automatic check_outputs();
    bit          ev;
    logic [31:0] w;
    logic [7:0]  inv;
    check("pll0_locked", pll0_locked, e >= LOCK);
    check("dly_rdy", {dly2, dly3, dly4}, {3{e >= LOCK + DLY}});
    check("rst_seq_done", rsd, e >= LOCK + DLY + 1);
    check("vtc_rdy", {vtc2, vtc3, vtc4},
          {(e >= LOCK + DLY + 2) && en2, (e >= LOCK + DLY + 2) && en3, (e >= LOCK + DLY + 2) && en4});
    ev = (exp_edge_q.size() > 0) && (exp_edge_q[0] == e);
    check("rd_valid", rd_valid, ev);
    if (ev) begin
      w = exp_q.pop_front();
      void'(exp_edge_q.pop_front());
      last_words = w;
      check("words", {d21, d22, d26, d27}, w);
      check("clk_p_word", d26, 8'hAA);
      if (!diff_done) check("clk_n_word", d27, 8'h55);
      inv = ~d21;
      check("n_is_not_p", d22, inv);
      if (n_valid < 16) check("data_inc", d21, 8'(n_valid));
      n_valid++;
    end else begin
      check("data_hold", {d21, d22, d26, d27}, last_words);
    end
    check("fifo_empty", {e21, e22, e26, e27}, {4{exp_edge_q.size() == 0}});
`ifdef HPIO_RX_DIFF_CHECK_EN
    check("diff_err", diff_err, diff_exp);
`endif
  endtask

  // Called at a falling edge: drive the bits for the next rising edge,
  // advance one clk, update the model and compare.
  task automatic tick();
    int         ne, k, p;
    logic [3:0] b;
    logic [7:0] pat;
    pat = 8'hAA;
    ne  = e + 1;
    k   = ne - FIRST_SHIFT;
    if (k >= 0) begin
      p = k % 8;
      if (p == 0) cur_byte = (k / 8 < 16) ? 8'(k / 8) : 8'($urandom_range(0, 255));
      b[0] = cur_byte[7 - p];
      b[2] = pat[7 - p];
    end else begin
      b[0] = 1'($urandom_range(0, 1));
      b[2] = 1'($urandom_range(0, 1));
    end
    b[1] = ~b[0];
    b[3] = ~b[2];
    if (ne == diff_at) begin
      b[3]      = b[2];
      diff_done = 1'b1;
    end
    data_p  = b[0];
    data_n  = b[1];
    ck_p    = b[2];
    ck_n    = b[3];
    pin0_nc = 1'($urandom_range(0, 1));
    en2     = 1'b1;
    en4     = 1'b1;
    en3     = !(vtc_test && ne >= vtc_off_at && ne < vtc_off_at + 4);
    @(posedge clk);
    e = ne;
    #1;
    if (k >= 0) begin
      for (int l = 0; l < 4; l++) hist[l] = {hist[l][6:0], b[l]};
      if (!aligned && k >= 7 && hist[2] == 8'hAA) begin
        aligned = 1'b1;
        kb      = k;
        exp_q.push_back({hist[0], hist[1], hist[2], hist[3]});
        exp_edge_q.push_back(e + 1);
      end else if (aligned && k > kb && (k - kb) % 8 == 0) begin
        exp_q.push_back({hist[0], hist[1], hist[2], hist[3]});
        exp_edge_q.push_back(e + 1);
      end
    end
    if (e == diff_at) diff_exp = 1'b1;
    check_outputs();
    @(negedge clk);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int n_edges;
    n_checks = 0;
    n_errors = 0;
    rst      = 1'b0;
    pin0_nc  = 1'b0;
    data_p   = 1'b0;
    data_n   = 1'b1;
    ck_p     = 1'b0;
    ck_n     = 1'b1;
    en2      = 1'b1;
    en3      = 1'b1;
    en4      = 1'b1;
    reset_model();
    repeat (3) @(negedge clk);
    check_reset_values();

    // Session 1: startup, alignment, RUN, then asynchronous reset mid-RUN.
    rst     = 1'b1;
    n_edges = FIRST_SHIFT + $urandom_range(60, 200);
    for (int i = 0; i < n_edges; i++) tick();
    #2;
    rst = 1'b0;
    #1;
    check_reset_values();
    @(negedge clk);
    reset_model();

    // Session 2: same startup timing, VTC enable drop, random data words.
    vtc_test   = 1'b1;
    vtc_off_at = $urandom_range(100, 200);
`ifdef HPIO_RX_DIFF_CHECK_EN
    diff_at = FIRST_SHIFT + $urandom_range(150, 250);
`endif
    rst     = 1'b1;
    n_edges = FIRST_SHIFT + 7 + 8 * 40;
    for (int i = 0; i < n_edges; i++) tick();
    #2;
    rst = 1'b0;
    #1;
    check_reset_values();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
